tl_ul_ram_responder: RTL

TL_UL_RAM_RESPONDER -- requirements
Module: tl_ul_ram_responder

---
 rtl/tl_ul_ram_responder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/tl_ul_ram_responder.sv
// TileLink-UL single-beat RAM manager: one 32-bit word array behind an address window,
// one registered response slot on the D channel.
module tl_ul_ram_responder #(
  parameter logic [29:0] ADDR_BASE  = 30'h0800_0000,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        auto_in_a_valid,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [3:0]  auto_in_a_bits_size,
  input  logic [3:0]  auto_in_a_bits_source,
  input  logic [29:0] auto_in_a_bits_address,
  input  logic [3:0]  auto_in_a_bits_mask,
  input  logic [31:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,
  output logic        auto_in_a_ready,

  input  logic        auto_in_d_ready,
  output logic        auto_in_d_valid,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [1:0]  auto_in_d_bits_param,
  output logic [3:0]  auto_in_d_bits_size,
  output logic [3:0]  auto_in_d_bits_source,
  output logic        auto_in_d_bits_sink,
  output logic        auto_in_d_bits_denied,
  output logic [31:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_corrupt
);

  localparam int unsigned Words  = 1 << DEPTH_LOG2;
  localparam int unsigned TagLsb = DEPTH_LOG2 + 2;

  localparam logic [2:0] OpPutFull    = 3'd0;
  localparam logic [2:0] OpPutPartial = 3'd1;
  localparam logic [2:0] OpArith      = 3'd2;
  localparam logic [2:0] OpLogical    = 3'd3;
  localparam logic [2:0] OpGet        = 3'd4;
  localparam logic [2:0] OpAccessAck  = 3'd0;
  localparam logic [2:0] OpAckData    = 3'd1;

  typedef enum logic {StEmpty, StFull} state_e;

  state_e                state_q;
  logic [2:0]            opcode_q, opcode_d;
  logic [3:0]            size_q;
  logic [3:0]            source_q;
  logic                  denied_q, denied_d;
  logic                  corrupt_q, corrupt_d;
  logic                  rd_q, rd_d;
  logic [31:0]           rdata_q;
  logic [31:0]           mem_q [Words];

  logic                  a_fire, d_fire;
  logic                  in_window, aligned, legal, wr_req;
  logic [3:0]            lane_grp;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  unused_param;

  assign unused_param = ^auto_in_a_bits_param;

  assign auto_in_d_valid = (state_q == StFull);
  assign auto_in_a_ready = ~auto_in_d_valid | auto_in_d_ready;
  assign a_fire          = auto_in_a_valid & auto_in_a_ready;
  assign d_fire          = auto_in_d_valid & auto_in_d_ready;

  assign word_idx  = auto_in_a_bits_address[TagLsb-1:2];
  assign in_window = auto_in_a_bits_address[29:TagLsb] == ADDR_BASE[29:TagLsb];

  // Sizes above one word leave lane_grp empty and aligned low, so they fall out as illegal.
  always_comb begin
    lane_grp = 4'h0;
    aligned  = 1'b0;
    case (auto_in_a_bits_size)
      4'd0: begin
        lane_grp = 4'b0001 << auto_in_a_bits_address[1:0];
        aligned  = 1'b1;
      end
      4'd1: begin
        lane_grp = 4'b0011 << {auto_in_a_bits_address[1], 1'b0};
        aligned  = ~auto_in_a_bits_address[0];
      end
      4'd2: begin
        lane_grp = 4'hF;
        aligned  = (auto_in_a_bits_address[1:0] == 2'b00);
      end
      default: ;
    endcase
  end

  always_comb begin
    legal = in_window & aligned & ((auto_in_a_bits_mask & ~lane_grp) == 4'h0);
    if (auto_in_a_bits_opcode == OpPutFull && auto_in_a_bits_mask != lane_grp) begin
      legal = 1'b0;
    end
  end

  always_comb begin
    opcode_d  = OpAccessAck;
    denied_d  = 1'b1;
    corrupt_d = 1'b0;
    rd_d      = 1'b0;
    wr_req    = 1'b0;
    case (auto_in_a_bits_opcode)
      OpPutFull, OpPutPartial: begin
        denied_d = ~legal;
        wr_req   = legal & ~auto_in_a_bits_corrupt;
      end
      OpGet: begin
        opcode_d  = OpAckData;
        denied_d  = ~legal;
        corrupt_d = ~legal;
        rd_d      = legal;
      end
      OpArith, OpLogical: begin
        opcode_d  = OpAckData;
        corrupt_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Array and its read register are deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (a_fire && wr_req && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (auto_in_a_bits_mask[i]) begin
          mem_q[word_idx][8*i +: 8] <= auto_in_a_bits_data[8*i +: 8];
        end
      end
    end
    if (a_fire && rd_d) begin
      rdata_q <= mem_q[word_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StEmpty;
      opcode_q  <= 3'd0;
      size_q    <= 4'd0;
      source_q  <= 4'd0;
      denied_q  <= 1'b0;
      corrupt_q <= 1'b0;
      rd_q      <= 1'b0;
    end else if (a_fire) begin
      state_q   <= StFull;
      opcode_q  <= opcode_d;
      size_q    <= auto_in_a_bits_size;
      source_q  <= auto_in_a_bits_source;
      denied_q  <= denied_d;
      corrupt_q <= corrupt_d;
      rd_q      <= rd_d;
    end else if (d_fire) begin
      state_q   <= StEmpty;
    end
  end

  assign auto_in_d_bits_opcode  = opcode_q;
  assign auto_in_d_bits_param   = 2'd0;
  assign auto_in_d_bits_size    = size_q;
  assign auto_in_d_bits_source  = source_q;
  assign auto_in_d_bits_sink    = 1'b0;
  assign auto_in_d_bits_denied  = denied_q;
  assign auto_in_d_bits_corrupt = corrupt_q;
  assign auto_in_d_bits_data    = rd_q ? rdata_q : 32'h0;

endmodule
